// File: rtl/scalar_fust.sv
// rtl/scalar_fust.sv - scalar functional-unit status table between dispatch and the ALU/LD_ST/BRANCH units
//
// Purpose: one row per FU holds its single in-flight op with RAW source tags;
// a register result-status table records which FU will produce each register.
// An op is released to its FU once both source tags are clear, and the row is
// retired on writeback.
//
// Optional feature macro: FUST_FLUSH_EN adds a synchronous flush input.
//
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   disp_valid/fu/rd/rs1/rs2       decoded instruction from dispatch
//   disp_stall                     dispatch must hold the instruction
//   issue_valid/ready [NUM_FU]     per-FU release handshake
//   issue_rd/rs1/rs2               per-FU register fields, slice i = FU i
//   wb_valid, wb_fu                FU completion
//   flush                          (FUST_FLUSH_EN only) clear all rows and register status
module scalar_fust #(
  parameter int NUM_FU  = 3,
  parameter int FU_W    = 2,
  parameter int REG_W   = 5,
  parameter int NUM_REG = 32
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    disp_valid,
  input  logic [FU_W-1:0]         disp_fu,
  input  logic [REG_W-1:0]        disp_rd,
  input  logic [REG_W-1:0]        disp_rs1,
  input  logic [REG_W-1:0]        disp_rs2,
  output logic                    disp_stall,
  output logic [NUM_FU-1:0]       issue_valid,
  input  logic [NUM_FU-1:0]       issue_ready,
  output logic [NUM_FU*REG_W-1:0] issue_rd,
  output logic [NUM_FU*REG_W-1:0] issue_rs1,
  output logic [NUM_FU*REG_W-1:0] issue_rs2,
  input  logic                    wb_valid,
  input  logic [FU_W-1:0]         wb_fu
`ifdef FUST_FLUSH_EN
  ,
  input  logic                    flush
`endif
);

  logic [NUM_FU-1:0]  r_busy;
  logic [NUM_FU-1:0]  r_issued;
  logic [NUM_FU-1:0]  r_t1_v;
  logic [NUM_FU-1:0]  r_t2_v;
  logic [FU_W-1:0]    r_t1_fu [NUM_FU];
  logic [FU_W-1:0]    r_t2_fu [NUM_FU];
  logic [REG_W-1:0]   r_rd    [NUM_FU];
  logic [REG_W-1:0]   r_rs1   [NUM_FU];
  logic [REG_W-1:0]   r_rs2   [NUM_FU];
  logic [NUM_REG-1:0] r_rs_v;
  logic [FU_W-1:0]    r_rs_fu [NUM_REG];

  logic              w_flush;
  logic              w_fu_ok;
  logic              w_sel_busy;
  logic [NUM_FU-1:0] w_disp_oh;
  logic [NUM_FU-1:0] w_wb_oh;
  logic [REG_W-1:0]  w_wb_rd;
  logic              w_wb;
  logic              w_waw;
  logic              w_accept;
  logic              w_t1_v;
  logic              w_t2_v;

`ifdef FUST_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Decode dispatch/writeback FU codes against the rows that exist; codes at
  // or above NUM_FU match no row. Writeback only counts for a busy, issued row.
  always_comb begin
    w_fu_ok    = 1'b0;
    w_sel_busy = 1'b0;
    w_disp_oh  = '0;
    w_wb_oh    = '0;
    w_wb_rd    = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (disp_fu == FU_W'(i)) begin
        w_fu_ok      = 1'b1;
        w_sel_busy   = r_busy[i];
        w_disp_oh[i] = 1'b1;
      end
      if (wb_valid && wb_fu == FU_W'(i) && r_busy[i] && r_issued[i]) begin
        w_wb_oh[i] = 1'b1;
        w_wb_rd    = r_rd[i];
      end
    end
  end

  assign w_wb       = |w_wb_oh;
  assign w_waw      = (disp_rd != '0) && r_rs_v[disp_rd];
  assign disp_stall = disp_valid && !w_flush && (w_sel_busy || w_waw || !w_fu_ok);
  assign w_accept   = disp_valid && !disp_stall && !w_flush;

  // A producer completing in the accept cycle is treated as already done.
  assign w_t1_v = (disp_rs1 != '0) && r_rs_v[disp_rs1] && !(w_wb && r_rs_fu[disp_rs1] == wb_fu);
  assign w_t2_v = (disp_rs2 != '0) && r_rs_v[disp_rs2] && !(w_wb && r_rs_fu[disp_rs2] == wb_fu);

  always_comb begin
    issue_valid = '0;
    issue_rd    = '0;
    issue_rs1   = '0;
    issue_rs2   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      issue_valid[i] = r_busy[i] && !r_issued[i] && !r_t1_v[i] && !r_t2_v[i];
      if (r_busy[i]) begin
        issue_rd [i*REG_W +: REG_W] = r_rd[i];
        issue_rs1[i*REG_W +: REG_W] = r_rs1[i];
        issue_rs2[i*REG_W +: REG_W] = r_rs2[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_busy   <= '0;
      r_issued <= '0;
      r_t1_v   <= '0;
      r_t2_v   <= '0;
      r_rs_v   <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        r_t1_fu[i] <= '0;
        r_t2_fu[i] <= '0;
        r_rd[i]    <= '0;
        r_rs1[i]   <= '0;
        r_rs2[i]   <= '0;
      end
      for (int r = 0; r < NUM_REG; r++) r_rs_fu[r] <= '0;
    end else if (w_flush) begin
      r_busy   <= '0;
      r_issued <= '0;
      r_t1_v   <= '0;
      r_t2_v   <= '0;
      r_rs_v   <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (issue_valid[i] && issue_ready[i]) r_issued[i] <= 1'b1;
        if (w_wb_oh[i]) begin
          r_busy[i]   <= 1'b0;
          r_issued[i] <= 1'b0;
        end
        if (w_wb && r_t1_v[i] && r_t1_fu[i] == wb_fu) r_t1_v[i] <= 1'b0;
        if (w_wb && r_t2_v[i] && r_t2_fu[i] == wb_fu) r_t2_v[i] <= 1'b0;
        // The accepted row is never busy, so this load cannot collide with
        // the issue/writeback updates above; it overrides the tag clears.
        if (w_accept && w_disp_oh[i]) begin
          r_busy[i]   <= 1'b1;
          r_issued[i] <= 1'b0;
          r_rd[i]     <= disp_rd;
          r_rs1[i]    <= disp_rs1;
          r_rs2[i]    <= disp_rs2;
          r_t1_v[i]   <= w_t1_v;
          r_t1_fu[i]  <= r_rs_fu[disp_rs1];
          r_t2_v[i]   <= w_t2_v;
          r_t2_fu[i]  <= r_rs_fu[disp_rs2];
        end
      end
      // Clear before set: a dispatch reusing the completing rd is WAW-stalled,
      // so both never target the same entry in one cycle.
      if (w_wb && r_rs_v[w_wb_rd] && r_rs_fu[w_wb_rd] == wb_fu) r_rs_v[w_wb_rd] <= 1'b0;
      if (w_accept && disp_rd != '0) begin
        r_rs_v[disp_rd]  <= 1'b1;
        r_rs_fu[disp_rd] <= disp_fu;
      end
    end
  end

endmodule

// File: tb/tb_scalar_fust.sv
// tb/tb_scalar_fust.sv - self-checking bench for scalar_fust with a behavioural scoreboard model
module tb_scalar_fust;

  logic        CLK;
  logic        nRST;
  logic        disp_valid;
  logic [1:0]  disp_fu;
  logic [4:0]  disp_rd;
  logic [4:0]  disp_rs1;
  logic [4:0]  disp_rs2;
  logic        disp_stall;
  logic [2:0]  issue_valid;
  logic [2:0]  issue_ready;
  logic [14:0] issue_rd;
  logic [14:0] issue_rs1;
  logic [14:0] issue_rs2;
  logic        wb_valid;
  logic [1:0]  wb_fu;
  logic        flush;

  scalar_fust dut (
    .CLK(CLK), .nRST(nRST),
    .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_rd(disp_rd),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_stall(disp_stall),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .wb_valid(wb_valid), .wb_fu(wb_fu)
`ifdef FUST_FLUSH_EN
    , .flush(flush)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic obs_stall;

  // Reference model: each FU holds at most one instruction; dep = FU code of
  // a still-pending producer of that source, -1 when the source is available.
  // owner[r] = FU that will write r, -1 when r is not pending.
  int m_busy[3], m_iss[3], m_rd[3], m_rs1[3], m_rs2[3], m_dep1[3], m_dep2[3];
  int m_owner[32];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0; m_iss[i] = 0; m_dep1[i] = -1; m_dep2[i] = -1;
      m_rd[i] = 0; m_rs1[i] = 0; m_rs2[i] = 0;
    end
    for (int r = 0; r < 32; r++) m_owner[r] = -1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int src_dep(input int rs, input bit wb_eff, input int wfu);
    if (rs == 0 || m_owner[rs] < 0) return -1;
    if (wb_eff && m_owner[rs] == wfu) return -1;
    return m_owner[rs];
  endfunction

  // One clock cycle: drive, check combinational and row-state outputs against
  // the model, clock, then advance the model.
  task automatic cyc(input bit dv, input int dfu, input int rd, input int rs1, input int rs2,
                     input logic [2:0] ir, input bit wv, input int wfu);
    logic [2:0]  e_iv;
    logic [14:0] e_rd, e_rs1, e_rs2;
    bit e_stall, wb_eff, acc, fl;
    int n_busy[3], n_iss[3], n_rd[3], n_rs1[3], n_rs2[3], n_dep1[3], n_dep2[3], n_owner[32];
    disp_valid = dv; disp_fu = 2'(dfu); disp_rd = 5'(rd); disp_rs1 = 5'(rs1); disp_rs2 = 5'(rs2);
    issue_ready = ir; wb_valid = wv; wb_fu = 2'(wfu);
    fl = flush;
    #1;
    e_iv = '0; e_rd = '0; e_rs1 = '0; e_rs2 = '0;
    for (int i = 0; i < 3; i++) begin
      e_iv[i] = m_busy[i] != 0 && m_iss[i] == 0 && m_dep1[i] < 0 && m_dep2[i] < 0;
      if (m_busy[i] != 0) begin
        e_rd [i*5 +: 5] = 5'(m_rd[i]);
        e_rs1[i*5 +: 5] = 5'(m_rs1[i]);
        e_rs2[i*5 +: 5] = 5'(m_rs2[i]);
      end
    end
    e_stall = dv && !fl && (dfu > 2 || m_busy[dfu] != 0 || (rd != 0 && m_owner[rd] >= 0));
    obs_stall = disp_stall;
    chk("disp_stall", 32'(disp_stall), 32'(e_stall));
    chk("issue_valid", 32'(issue_valid), 32'(e_iv));
    chk("issue_rd", 32'(issue_rd), 32'(e_rd));
    chk("issue_rs1", 32'(issue_rs1), 32'(e_rs1));
    chk("issue_rs2", 32'(issue_rs2), 32'(e_rs2));

    wb_eff = wv && wfu <= 2 && m_busy[wfu] != 0 && m_iss[wfu] != 0;
    acc = dv && !e_stall && !fl;
    n_busy = m_busy; n_iss = m_iss; n_rd = m_rd; n_rs1 = m_rs1; n_rs2 = m_rs2;
    n_dep1 = m_dep1; n_dep2 = m_dep2; n_owner = m_owner;
    for (int i = 0; i < 3; i++) if (e_iv[i] && ir[i]) n_iss[i] = 1;
    if (wb_eff) begin
      n_busy[wfu] = 0; n_iss[wfu] = 0;
      for (int i = 0; i < 3; i++) begin
        if (m_dep1[i] == wfu) n_dep1[i] = -1;
        if (m_dep2[i] == wfu) n_dep2[i] = -1;
      end
      if (m_rd[wfu] != 0 && m_owner[m_rd[wfu]] == wfu) n_owner[m_rd[wfu]] = -1;
    end
    if (acc) begin
      n_busy[dfu] = 1; n_iss[dfu] = 0;
      n_rd[dfu] = rd; n_rs1[dfu] = rs1; n_rs2[dfu] = rs2;
      n_dep1[dfu] = src_dep(rs1, wb_eff, wfu);
      n_dep2[dfu] = src_dep(rs2, wb_eff, wfu);
      if (rd != 0) n_owner[rd] = dfu;
    end
    @(posedge CLK);
    #1;
    if (fl) model_reset();
    else begin
      m_busy = n_busy; m_iss = n_iss; m_rd = n_rd; m_rs1 = n_rs1; m_rs2 = n_rs2;
      m_dep1 = n_dep1; m_dep2 = n_dep2; m_owner = n_owner;
    end
    disp_valid = 1'b0; wb_valid = 1'b0; issue_ready = '0;
  endtask

  task automatic idle(input logic [2:0] ir, input bit wv, input int wfu);
    cyc(0, 0, 0, 0, 0, ir, wv, wfu);
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0;
    disp_valid = 1'b0; disp_fu = '0; disp_rd = '0; disp_rs1 = '0; disp_rs2 = '0;
    issue_ready = '0; wb_valid = 1'b0; wb_fu = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_stall", 32'(disp_stall), 32'h0);
    chk("rst_iv", 32'(issue_valid), 32'h0);
    chk("rst_fields", 32'(issue_rd | issue_rs1 | issue_rs2), 32'h0);
    nRST = 1'b1;

    // Basic issue of an ALU op with no pending sources.
    cyc(1, 0, 3, 1, 2, 3'b000, 0, 0);
    chk("t1_iv", 32'(issue_valid), 32'h1);
    chk("t1_rd0", 32'(issue_rd[4:0]), 32'd3);
    idle(3'b001, 0, 0);
    chk("t1_iv_taken", 32'(issue_valid[0]), 32'h0);
    idle(3'b000, 1, 0);

    // RAW wait and wakeup on writeback.
    cyc(1, 0, 5, 0, 0, 3'b000, 0, 0);
    cyc(1, 1, 0, 5, 0, 3'b001, 0, 0);
    chk("t2_ld_wait", 32'(issue_valid[1]), 32'h0);
    idle(3'b000, 1, 0);
    chk("t2_ld_wake", 32'(issue_valid[1]), 32'h1);
    idle(3'b010, 0, 0);
    idle(3'b000, 1, 1);

    // Structural stall and release after writeback.
    cyc(1, 0, 1, 0, 0, 3'b000, 0, 0);
    cyc(1, 0, 2, 0, 0, 3'b000, 0, 0);
    chk("t3_struct", 32'(obs_stall), 32'h1);
    chk("t3_keep_rd", 32'(issue_rd[4:0]), 32'd1);
    idle(3'b001, 0, 0);
    idle(3'b000, 1, 0);
    cyc(1, 0, 2, 0, 0, 3'b000, 0, 0);
    chk("t3_free", 32'(obs_stall), 32'h0);
    idle(3'b001, 0, 0);
    idle(3'b000, 1, 0);

    // WAW stall, then same-cycle writeback bypass to a new source tag.
    cyc(1, 0, 7, 0, 0, 3'b000, 0, 0);
    idle(3'b001, 0, 0);
    cyc(1, 2, 7, 0, 0, 3'b000, 0, 0);
    chk("t4_waw", 32'(obs_stall), 32'h1);
    cyc(1, 2, 0, 7, 0, 3'b000, 1, 0);
    chk("t4_bypass_ok", 32'(obs_stall), 32'h0);
    chk("t4_br_iv", 32'(issue_valid), 32'h4);
    idle(3'b100, 0, 0);
    idle(3'b000, 1, 2);

    // Register 0 never creates hazards; illegal FU code always stalls.
    cyc(1, 0, 0, 0, 0, 3'b000, 0, 0);
    cyc(1, 1, 0, 0, 0, 3'b000, 0, 0);
    chk("t5_r0", 32'(obs_stall), 32'h0);
    chk("t5_iv", 32'(issue_valid), 32'h3);
    cyc(1, 3, 4, 0, 0, 3'b011, 0, 0);
    chk("t5_illegal", 32'(obs_stall), 32'h1);
    idle(3'b000, 1, 0);
    idle(3'b000, 1, 1);

    // Asynchronous reset between edges discards all rows at once.
    cyc(1, 1, 9, 0, 0, 3'b000, 0, 0);
    #2 nRST = 1'b0;
    #1;
    chk("arst_iv", 32'(issue_valid), 32'h0);
    model_reset();
    @(posedge CLK);
    #1 nRST = 1'b1;

`ifdef FUST_FLUSH_EN
    cyc(1, 0, 3, 0, 0, 3'b000, 0, 0);
    cyc(1, 1, 4, 3, 0, 3'b001, 0, 0);
    flush = 1'b1;
    cyc(1, 2, 6, 0, 0, 3'b000, 1, 0);
    flush = 1'b0;
    chk("fl_iv", 32'(issue_valid), 32'h0);
    cyc(1, 0, 3, 0, 0, 3'b000, 1, 0);
    chk("fl_free", 32'(obs_stall), 32'h0);
    idle(3'b001, 0, 0);
    idle(3'b000, 1, 0);
`endif

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      int fu, wf;
      fu = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
      wf = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
`ifdef FUST_FLUSH_EN
      flush = ($urandom_range(0, 40) == 0);
`endif
      cyc($urandom_range(0, 1), fu, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7), 3'($urandom), $urandom_range(0, 1), wf);
    end
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
